// File: rtl/alaw_pkg.sv
// Shared widths, constants and FSM state type for the A-law style sample compressor.
// Optional ALAW_ROUND_NEAREST_EN selects round-to-nearest mantissa (see alaw_compressor).
package alaw_pkg;

   localparam int unsigned IN_W      = 24;
   localparam int unsigned CODE_W    = 15;
   localparam int unsigned MANT_W    = 7;
   localparam int unsigned EXP_W     = 7;
   localparam int unsigned K_W       = 5;   // holds k = 0..16
   localparam int unsigned V_W       = 8;   // packer operand: M < 34 or t <= 144
   localparam int unsigned MANT_BIAS = 17;
   localparam int unsigned K0_MIN    = 18;
   localparam int unsigned K0_LIMIT  = 34;
   localparam int unsigned T_MAX     = 144;
   localparam int unsigned K_MAX     = 16;

   typedef enum logic [1:0] {
      StIdle,
      StNorm,
      StPack,
      StHold
   } state_e;

endpackage

// File: rtl/alaw_pack.sv
// Combinational packer: {neg, k, t or M} -> signed 15-bit log code.
// ALAW_ROUND_NEAREST_EN moves the k=0 mantissa offset from 18 to 17.
module alaw_pack
   import alaw_pkg::*;
(
   input  logic              neg,
   input  logic [K_W-1:0]    k,
   input  logic [V_W-1:0]    val,
   output logic [CODE_W-1:0] code
);

`ifdef ALAW_ROUND_NEAREST_EN
   localparam int unsigned K0_OFFSET = 17;
`else
   localparam int unsigned K0_OFFSET = 18;
`endif

   logic [MANT_W-1:0] q;
   logic [CODE_W-1:0] pos;

   always_comb begin
      q = '0;
      if (k == '0) begin
         if (val >= V_W'(K0_MIN)) q = MANT_W'((val - V_W'(K0_OFFSET)) >> 1);
      end else begin
         q = MANT_W'(val - V_W'(MANT_BIAS));
      end
   end

   assign pos  = {1'b0, q, EXP_W'(k)};
   // Sign applied as two's complement of the whole code word.
   assign code = neg ? (~pos + CODE_W'(1)) : pos;

endmodule

// File: rtl/alaw_compressor.sv
// Iterative 24-bit sample -> 15-bit log code compressor, one normalising shift per clock.
// Define ALAW_ROUND_NEAREST_EN for round-to-nearest mantissa; default truncates.
module alaw_compressor
   import alaw_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   sample,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] code,
   output logic              busy
);

   state_e              state_q, state_d;
   logic                neg_q, neg_d;
   logic [IN_W-1:0]     r_q, r_d;
   logic [K_W-1:0]      k_q, k_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [IN_W-1:0]     mag;
   logic [IN_W-1:0]     t;
   logic [V_W-1:0]      pack_val;
   logic [CODE_W-1:0]   pack_code;

   // -2^23 maps to 2^23, which still fits as a 24-bit unsigned magnitude.
   assign mag = sample[IN_W-1] ? (~sample + IN_W'(1)) : sample;

`ifdef ALAW_ROUND_NEAREST_EN
   assign t = (r_q + IN_W'(1)) >> 1;
`else
   assign t = r_q >> 1;
`endif

   // k=0 packs the raw magnitude, otherwise the normalised value t.
   assign pack_val = (k_q == '0) ? r_q[V_W-1:0] : t[V_W-1:0];

   alaw_pack u_pack (
      .neg  (neg_q),
      .k    (k_q),
      .val  (pack_val),
      .code (pack_code)
   );

   always_comb begin
      state_d = state_q;
      neg_d   = neg_q;
      r_d     = r_q;
      k_d     = k_q;
      code_d  = code_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               neg_d = sample[IN_W-1];
               r_d   = mag;
               if (mag < IN_W'(K0_LIMIT)) begin
                  k_d     = '0;
                  state_d = StPack;
               end else begin
                  k_d     = K_W'(1);
                  state_d = StNorm;
               end
            end
         end
         StNorm: begin
            if (t <= IN_W'(T_MAX) || k_q == K_W'(K_MAX)) begin
               state_d = StPack;
            end else begin
               r_d = r_q >> 1;
               k_d = k_q + K_W'(1);
            end
         end
         StPack: begin
            code_d  = pack_code;
            state_d = StHold;
         end
         StHold: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         neg_q   <= 1'b0;
         r_q     <= '0;
         k_q     <= '0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         neg_q   <= neg_d;
         r_q     <= r_d;
         k_q     <= k_d;
         code_q  <= code_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StHold);
   assign busy      = (state_q != StIdle);
   assign code      = code_q;

endmodule
